// File: rtl/mem_responder_pkg.sv
// Shared types for the byte-serial memory bus responder.
package mem_responder_pkg;

    localparam int BUS_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        RX_B1,
        CLASSIFY,
        RX_D1,
        DELAY,
        TX_LO,
        TX_HI
    } resp_state_t;

    typedef enum logic {
        FETCH,
        MEM
    } txn_kind_t;

endpackage

// File: rtl/resp_ram.sv
// Word RAM behind the responder: store and preload write ports (store wins on
// a same-word collision) and a registered read port.
module resp_ram #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_we,
    input  logic [AW-1:0] st_addr,
    input  logic [15:0]   st_wdata,
    input  logic          pre_we,
    input  logic [AW-1:0] pre_addr,
    input  logic [15:0]   pre_wdata,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [15:0]   rd_data
);

    logic [15:0] mem [2**AW];
    logic        pre_ok;

    assign pre_ok = pre_we && !(st_we && (st_addr == pre_addr));

    always_ff @(posedge clk) begin
        if (pre_ok) mem[pre_addr] <= pre_wdata;
        if (st_we)  mem[st_addr]  <= st_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side endpoint of the 8-bit byte-serial CPU bus: collects PC/MAR/MDR
// byte pairs and answers fetches and loads from a local word RAM.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int AW         = 8,
    parameter int RESP_DELAY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BUS_W-1:0] bus_in,
    input  logic             bus_pc,
    input  logic             bus_mar,
    input  logic             bus_mdr,
    output logic             receive_ready,
    output logic             data_ready,
    output logic [BUS_W-1:0] bus_out,
    input  logic             pre_we,
    input  logic [AW-1:0]    pre_addr,
    input  logic [15:0]      pre_wdata,
    output logic             proto_err
);

    // state    | meaning
    // IDLE     | waiting for the first PC or MAR byte
    // RX_B1    | waiting for the second byte of the same kind
    // CLASSIFY | MEM txn: MDR byte means store, silence means load
    // RX_D1    | waiting for the store-data high byte
    // DELAY    | response wait, RESP_DELAY cycles
    // TX_LO    | presenting the low response byte
    // TX_HI    | presenting the high response byte

    localparam resp_state_t RESP_START = (RESP_DELAY == 0) ? TX_LO : DELAY;
    localparam logic [7:0]  DLY_INIT   = 8'(RESP_DELAY - 1);

    resp_state_t state;
    txn_kind_t   kind;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  counter;
    logic [15:0] rd_word;
    logic [15:0] rd_full;
    logic        any_strobe;
    logic        single_addr_strobe;
    logic        fetch_go;
    logic        load_go;
    logic        st_we;

    assign any_strobe         = bus_pc | bus_mar | bus_mdr;
    assign single_addr_strobe = (bus_pc ^ bus_mar) & ~bus_mdr;
    assign fetch_go           = (state == RX_B1) && (kind == FETCH) && bus_pc;
    assign load_go            = (state == CLASSIFY) && !any_strobe;
    assign st_we              = (state == RX_D1) && bus_mdr;
    // A fetch reads on the same edge that latches addr[15:8], so bypass it.
    assign rd_full            = (state == RX_B1) ? {bus_in, addr[7:0]} : addr;

    resp_ram #(.AW(AW)) u_ram (
        .clk      (clk),
        .rst      (rst),
        .st_we    (st_we),
        .st_addr  (AW'(addr)),
        .st_wdata ({bus_in, data}),
        .pre_we   (pre_we),
        .pre_addr (pre_addr),
        .pre_wdata(pre_wdata),
        .rd_en    (fetch_go | load_go),
        .rd_addr  (AW'(rd_full)),
        .rd_data  (rd_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            kind      <= FETCH;
            addr      <= '0;
            data      <= '0;
            counter   <= '0;
            proto_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (single_addr_strobe) begin
                        addr[7:0] <= bus_in;
                        kind      <= bus_pc ? FETCH : MEM;
                        state     <= RX_B1;
                    end else if (any_strobe) begin
                        proto_err <= 1'b1;
                    end
                end
                RX_B1: begin
                    if ((kind == FETCH) ? bus_pc : bus_mar) begin
                        addr[15:8] <= bus_in;
                        if (kind == FETCH) begin
                            state   <= RESP_START;
                            counter <= DLY_INIT;
                        end else begin
                            state <= CLASSIFY;
                        end
                    end else begin
                        proto_err <= 1'b1;
                        state     <= IDLE;
                    end
                end
                CLASSIFY: begin
                    if (bus_pc || bus_mar) begin
                        proto_err <= 1'b1;
                        state     <= IDLE;
                    end else if (bus_mdr) begin
                        data  <= bus_in;
                        state <= RX_D1;
                    end else begin
                        state   <= RESP_START;
                        counter <= DLY_INIT;
                    end
                end
                RX_D1: begin
                    if (!bus_mdr) proto_err <= 1'b1;
                    state <= IDLE;
                end
                DELAY: begin
                    if (any_strobe) proto_err <= 1'b1;
                    if (counter == 8'd0) state <= TX_LO;
                    else                 counter <= counter - 8'd1;
                end
                TX_LO: begin
                    if (any_strobe) proto_err <= 1'b1;
                    state <= TX_HI;
                end
                TX_HI: begin
                    if (any_strobe) proto_err <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign receive_ready = (state == IDLE);
    assign data_ready    = (state == TX_LO) || (state == TX_HI);

    always_comb begin
        bus_out = '0;
        case (state)
            TX_LO:   bus_out = rd_word[7:0];
            TX_HI:   bus_out = rd_word[15:8];
            default: bus_out = '0;
        endcase
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: two instances (RESP_DELAY 2 and 0) share
// stimulus; a word-array model predicts responses and their arrival cycle.
module tb_mem_responder;

    localparam int AW = 8;
    localparam int RD = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  bus_in;
    logic        bus_pc, bus_mar, bus_mdr;
    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [15:0] pre_wdata;
    logic        rr2, dr2, pe2, rr0, dr0, pe0;
    logic [7:0]  bo2, bo0;

    mem_responder #(.AW(AW), .RESP_DELAY(RD)) dut (
        .clk(clk), .rst(rst), .bus_in(bus_in), .bus_pc(bus_pc), .bus_mar(bus_mar),
        .bus_mdr(bus_mdr), .receive_ready(rr2), .data_ready(dr2), .bus_out(bo2),
        .pre_we(pre_we), .pre_addr(pre_addr), .pre_wdata(pre_wdata), .proto_err(pe2)
    );

    mem_responder #(.AW(AW), .RESP_DELAY(0)) dut0 (
        .clk(clk), .rst(rst), .bus_in(bus_in), .bus_pc(bus_pc), .bus_mar(bus_mar),
        .bus_mdr(bus_mdr), .receive_ready(rr0), .data_ready(dr0), .bus_out(bo0),
        .pre_we(pre_we), .pre_addr(pre_addr), .pre_wdata(pre_wdata), .proto_err(pe0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] w;
        int          t;
    } exp_t;

    exp_t        q2[$];
    exp_t        q0[$];
    logic [15:0] model [256];
    logic        hi2 = 1'b0, hi0 = 1'b0;
    logic [7:0]  hb2, hb0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitors: a response is two consecutive data_ready cycles, low byte first.
    always @(negedge clk) begin
        if (rst) hi2 = 1'b0;
        else if (hi2) begin
            check("d2_hi_valid", 32'(dr2), 32'd1);
            check("d2_hi_byte", 32'(bo2), 32'(hb2));
            hi2 = 1'b0;
        end else if (dr2) begin
            if (q2.size() == 0) check("d2_unexpected_resp", 32'(dr2), 32'd0);
            else begin
                exp_t e;
                e = q2.pop_front();
                check("d2_lo_byte", 32'(bo2), 32'(e.w[7:0]));
                check("d2_latency", 32'(cyc), 32'(e.t));
                hb2 = e.w[15:8];
                hi2 = 1'b1;
            end
        end else check("d2_idle_bus_out", 32'(bo2), 32'd0);
    end

    always @(negedge clk) begin
        if (rst) hi0 = 1'b0;
        else if (hi0) begin
            check("d0_hi_valid", 32'(dr0), 32'd1);
            check("d0_hi_byte", 32'(bo0), 32'(hb0));
            hi0 = 1'b0;
        end else if (dr0) begin
            if (q0.size() == 0) check("d0_unexpected_resp", 32'(dr0), 32'd0);
            else begin
                exp_t e;
                e = q0.pop_front();
                check("d0_lo_byte", 32'(bo0), 32'(e.w[7:0]));
                check("d0_latency", 32'(cyc), 32'(e.t));
                hb0 = e.w[15:8];
                hi0 = 1'b1;
            end
        end else check("d0_idle_bus_out", 32'(bo0), 32'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input logic pc, input logic mar, input logic mdr, input logic [7:0] b);
        bus_pc  = pc;
        bus_mar = mar;
        bus_mdr = mdr;
        bus_in  = b;
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        pre_we    = 1'b1;
        pre_addr  = a;
        pre_wdata = d;
        step();
        pre_we    = 1'b0;
        model[a]  = d;
    endtask

    // lat: cycles from the second address byte to TX_LO beyond the delay.
    task automatic push_exp(input logic [15:0] w, input int lat);
        exp_t e;
        e.w = w;
        e.t = cyc + lat + RD;
        q2.push_back(e);
        e.t = cyc + lat;
        q0.push_back(e);
    endtask

    task automatic do_fetch(input logic [15:0] a);
        set_bus(1, 0, 0, a[7:0]);  step();
        set_bus(1, 0, 0, a[15:8]); push_exp(model[a[7:0]], 1); step();
        set_bus(0, 0, 0, 8'h00);
        repeat (RD + 1) step();
        check("fetch_busy_in_tx_hi", 32'(rr2), 32'd0);
        step();
        check("fetch_ready_again", 32'(rr2), 32'd1);
    endtask

    task automatic do_load(input logic [15:0] a);
        set_bus(0, 1, 0, a[7:0]);  step();
        set_bus(0, 1, 0, a[15:8]); push_exp(model[a[7:0]], 2); step();
        set_bus(0, 0, 0, 8'h00);
        repeat (RD + 2) step();
        check("load_busy_in_tx_hi", 32'(rr2), 32'd0);
        step();
        check("load_ready_again", 32'(rr2), 32'd1);
    endtask

    task automatic do_store(input logic [15:0] a, input logic [15:0] d, input logic collide);
        set_bus(0, 1, 0, a[7:0]);  step();
        set_bus(0, 1, 0, a[15:8]); step();
        set_bus(0, 0, 1, d[7:0]);  step();
        set_bus(0, 0, 1, d[15:8]);
        if (collide) begin
            pre_we    = 1'b1;
            pre_addr  = a[7:0];
            pre_wdata = 16'hFFFF;
        end
        model[a[7:0]] = d;
        step();
        pre_we = 1'b0;
        set_bus(0, 0, 0, 8'h00);
        check("store_back_in_idle", 32'(rr2), 32'd1);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        q2.delete();
        q0.delete();
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] a, d;
        int          op;
        rst = 1'b1;
        set_bus(0, 0, 0, 8'h00);
        pre_we = 1'b0; pre_addr = '0; pre_wdata = '0;
        step(); step();
        check("rst_receive_ready", 32'(rr2), 32'd1);
        check("rst_data_ready", 32'(dr2), 32'd0);
        check("rst_bus_out", 32'(bo2), 32'd0);
        check("rst_proto_err", 32'(pe2), 32'd0);
        check("rst0_receive_ready", 32'(rr0), 32'd1);
        rst = 1'b0;
        step();

        for (int i = 0; i < 256; i++) preload(8'(i), 16'($urandom));

        preload(8'h10, 16'hBEEF);
        do_fetch(16'h0010);
        check("fetch_no_proto_err", 32'(pe2), 32'd0);

        do_store(16'h0022, 16'h1234, 1'b0);
        do_load(16'h0022);

        preload(8'h33, 16'hA55A);
        do_fetch(16'h0033);

        do_store(16'h0105, 16'h5A0F, 1'b1);
        do_load(16'h0005);
        do_fetch(16'hFF05);

        // strobe while the response is in flight: flagged, response unaffected
        set_bus(1, 0, 0, 8'h10); step();
        set_bus(1, 0, 0, 8'h00); push_exp(model[8'h10], 1); step();
        set_bus(0, 1, 0, 8'h77); step();
        set_bus(0, 0, 0, 8'h00);
        repeat (RD + 3) step();
        check("inflight_strobe_err", 32'(pe2), 32'd1);
        check("inflight_strobe_err0", 32'(pe0), 32'd1);

        reset_pulse();
        check("err_cleared_by_rst", 32'(pe2), 32'd0);
        set_bus(1, 0, 0, 8'h01); step();
        set_bus(0, 1, 0, 8'h02); step();
        set_bus(0, 0, 0, 8'h00);
        check("pc_then_mar_err", 32'(pe2), 32'd1);
        check("pc_then_mar_idle", 32'(rr2), 32'd1);

        reset_pulse();
        preload(8'h40, 16'h7777);
        set_bus(0, 1, 0, 8'h40); step();
        set_bus(0, 1, 0, 8'h00); step();
        set_bus(0, 0, 1, 8'hCD); step();
        set_bus(0, 0, 0, 8'h00); step();
        check("half_mdr_err", 32'(pe2), 32'd1);
        check("half_mdr_idle", 32'(rr2), 32'd1);
        do_load(16'h0040);

        reset_pulse();
        set_bus(0, 0, 1, 8'h55); step();
        set_bus(0, 0, 0, 8'h00); step();
        check("mdr_alone_err", 32'(pe2), 32'd1);

        // async reset while dut waits in DELAY (dut0 is already in TX_LO)
        reset_pulse();
        set_bus(0, 1, 0, 8'h22); step();
        set_bus(0, 1, 0, 8'h00); step();
        set_bus(0, 0, 0, 8'h00); step();
        check("pre_rst_in_delay", 32'(rr2), 32'd0);
        check("pre_rst0_in_tx", 32'(dr0), 32'd1);
        rst = 1'b1;
        q2.delete();
        q0.delete();
        #1;
        check("async_rst_ready", 32'(rr2), 32'd1);
        check("async_rst_dr", 32'(dr2), 32'd0);
        check("async_rst0_dr", 32'(dr0), 32'd0);
        check("async_rst0_bus_out", 32'(bo0), 32'd0);
        step(); step();
        rst = 1'b0;
        step();
        do_fetch(16'h0010);

        repeat (80) begin
            op = $urandom_range(0, 3);
            a  = 16'($urandom);
            d  = 16'($urandom);
            case (op)
                0: do_fetch(a);
                1: do_load(a);
                2: do_store(a, d, 1'($urandom_range(0, 1)));
                default: preload(a[7:0], d);
            endcase
        end
        check("random_no_proto_err", 32'(pe2), 32'd0);
        check("random_no_proto_err0", 32'(pe0), 32'd0);

        for (int i = 0; i < 20 && (q2.size() != 0 || q0.size() != 0); i++) step();
        check("drain_q2", 32'(q2.size()), 32'd0);
        check("drain_q0", 32'(q0.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
